// File: rtl/sm_fv_pingpong_buf.sv
// sm_fv_pingpong_buf
// Small-FV-side ping-pong receiver for the big FV bank controller's iteration
// stream. One buffer captures the incoming replay iteration while the edge-PE
// side reads the other, previously completed buffer.
//
// Optional feature macro: SM_FV_PARITY_EN adds per-line even parity with
// read-side checking (rd_perr) and a parity-corruption debug input (inj_perr).
//
// Ports:
//   clk, reset           clock, asynchronous active-low reset
//   s_valid/s_sos/s_eos  stream beat qualifiers (first/last beat of iteration)
//   s_addr, s_data       line address and line data of the beat
//   s_ready              the fill buffer can take a stream
//   rd_req, rd_addr      edge-PE read request and line address
//   rd_valid, rd_data    registered read response (1-cycle latency)
//   rd_err               read attempted with no completed buffer (pulse)
//   rel                  consumer releases the current read buffer
//   rd_bank_rdy          a completed buffer is selected for reading
//   ovf                  sticky: a stream beat was dropped
//   inj_perr, rd_perr    (SM_FV_PARITY_EN only) parity inject / parity error
module sm_fv_pingpong_buf #(
  parameter int unsigned FV_W  = 64,
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_valid,
  input  logic            s_sos,
  input  logic            s_eos,
  input  logic [AW-1:0]   s_addr,
  input  logic [FV_W-1:0] s_data,
  output logic            s_ready,
  input  logic            rd_req,
  input  logic [AW-1:0]   rd_addr,
  output logic            rd_valid,
  output logic [FV_W-1:0] rd_data,
  output logic            rd_err,
  input  logic            rel,
  output logic            rd_bank_rdy,
  output logic            ovf
`ifdef SM_FV_PARITY_EN
  ,
  input  logic            inj_perr,
  output logic            rd_perr
`endif
);

  localparam int unsigned NLINES = 2 * DEPTH;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL  = 2'd1,
    DONE  = 2'd2
  } buf_state_e;

  buf_state_e      st_q [2];
  buf_state_e      st_d [2];
  logic            wr_sel_q, wr_sel_d;
  logic            rd_sel_q, rd_sel_d;
  logic            s_ready_d, rd_bank_rdy_d, ovf_d;
  logic            rd_valid_d, rd_err_d;
  logic [FV_W-1:0] rd_data_d;

  // Both buffers live in one array; the MSB of the line index selects B0/B1.
  logic [FV_W-1:0] mem [NLINES];
  logic            we;
  logic [AW:0]     waddr;
  logic [AW:0]     raddr;
  logic [FV_W-1:0] rd_line;

  assign waddr   = {wr_sel_q, s_addr};
  assign raddr   = {rd_sel_q, rd_addr};
  assign rd_line = mem[raddr];

  // Next-state: buffer states, pointers, and the registered output values.
  always_comb begin
    st_d[0]    = st_q[0];
    st_d[1]    = st_q[1];
    wr_sel_d   = wr_sel_q;
    rd_sel_d   = rd_sel_q;
    ovf_d      = ovf;
    we         = 1'b0;
    rd_valid_d = 1'b0;
    rd_err_d   = 1'b0;
    rd_data_d  = rd_data;

    // Fill side. s_ready mirrors "fill buffer is not DONE".
    if (s_valid) begin
      if (!s_ready) begin
        ovf_d = 1'b1;
      end else if (st_q[wr_sel_q] == EMPTY && !s_sos) begin
        ovf_d = 1'b1;
      end else begin
        // sos in FILL simply restarts; the line is still written.
        we = 1'b1;
        if (s_eos) begin
          st_d[wr_sel_q] = DONE;
          wr_sel_d       = ~wr_sel_q;
        end else begin
          st_d[wr_sel_q] = FILL;
        end
      end
    end

    // Read side; a same-cycle rel still sees the old buffer.
    if (rd_req) begin
      if (rd_bank_rdy) begin
        rd_valid_d = 1'b1;
        rd_data_d  = rd_line;
      end else begin
        rd_data_d = '0;
        rd_err_d  = 1'b1;
      end
    end

    // Release never collides with the fill update: a DONE read buffer cannot
    // be the fill buffer while s_ready is high.
    if (rel && rd_bank_rdy) begin
      st_d[rd_sel_q] = EMPTY;
      rd_sel_d       = ~rd_sel_q;
    end

    s_ready_d     = (st_d[wr_sel_d] != DONE);
    rd_bank_rdy_d = (st_d[rd_sel_d] == DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q[0]     <= EMPTY;
      st_q[1]     <= EMPTY;
      wr_sel_q    <= 1'b0;
      rd_sel_q    <= 1'b0;
      s_ready     <= 1'b1;
      rd_bank_rdy <= 1'b0;
      ovf         <= 1'b0;
      rd_valid    <= 1'b0;
      rd_err      <= 1'b0;
      rd_data     <= '0;
    end else begin
      st_q[0]     <= st_d[0];
      st_q[1]     <= st_d[1];
      wr_sel_q    <= wr_sel_d;
      rd_sel_q    <= rd_sel_d;
      s_ready     <= s_ready_d;
      rd_bank_rdy <= rd_bank_rdy_d;
      ovf         <= ovf_d;
      rd_valid    <= rd_valid_d;
      rd_err      <= rd_err_d;
      rd_data     <= rd_data_d;
    end
  end

  // Line storage; contents are don't-care until a buffer reaches DONE.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= s_data;
    end
  end

`ifdef SM_FV_PARITY_EN
  logic par_mem [NLINES];
  logic rd_perr_d;

  // Even parity bit: stored bit makes the line plus parity have even weight.
  always_ff @(posedge clk) begin
    if (we) begin
      par_mem[waddr] <= (^s_data) ^ inj_perr;
    end
  end

  assign rd_perr_d = rd_req & rd_bank_rdy & ((^rd_line) ^ par_mem[raddr]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_perr <= 1'b0;
    end else begin
      rd_perr <= rd_perr_d;
    end
  end
`endif

endmodule

// File: tb/tb_sm_fv_pingpong_buf.sv
// Testbench for sm_fv_pingpong_buf: directed stream/read/release scenarios,
// a buffer-level reference model checked every cycle, plus literal checks.
module tb_sm_fv_pingpong_buf;
  localparam int unsigned FV_W  = 64;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned AW    = 6;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            s_valid = 1'b0, s_sos = 1'b0, s_eos = 1'b0;
  logic [AW-1:0]   s_addr = '0;
  logic [FV_W-1:0] s_data = '0;
  logic            s_ready;
  logic            rd_req = 1'b0;
  logic [AW-1:0]   rd_addr = '0;
  logic            rd_valid;
  logic [FV_W-1:0] rd_data;
  logic            rd_err;
  logic            rel = 1'b0;
  logic            rd_bank_rdy;
  logic            ovf;
`ifdef SM_FV_PARITY_EN
  logic            inj_perr = 1'b0;
  logic            rd_perr;
`endif

  sm_fv_pingpong_buf #(.FV_W(FV_W), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_sos(s_sos), .s_eos(s_eos),
    .s_addr(s_addr), .s_data(s_data), .s_ready(s_ready),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid),
    .rd_data(rd_data), .rd_err(rd_err), .rel(rel),
    .rd_bank_rdy(rd_bank_rdy), .ovf(ovf)
`ifdef SM_FV_PARITY_EN
    , .inj_perr(inj_perr), .rd_perr(rd_perr)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: buffer status 0=empty, 1=filling, 2=complete.
  int              mst [2];
  bit              mws, mrs, rel_ok;
  logic [63:0]     mmem [2][DEPTH];
  bit              mbad [2][DEPTH];
  bit              m_ovf, m_valid, m_err, m_perr;
  logic [63:0]     m_data;
  bit              m_inj;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mst[0] = 0; mst[1] = 0;
      mws = 0; mrs = 0;
      m_ovf = 0; m_valid = 0; m_err = 0; m_perr = 0; m_data = '0;
    end else begin
      rel_ok = rel && (mst[mrs] == 2);
`ifdef SM_FV_PARITY_EN
      m_inj = inj_perr;
`else
      m_inj = 1'b0;
`endif
      m_valid = 0; m_err = 0; m_perr = 0;
      if (rd_req) begin
        if (mst[mrs] == 2) begin
          m_valid = 1;
          m_data  = mmem[mrs][rd_addr];
          m_perr  = mbad[mrs][rd_addr];
        end else begin
          m_data = '0;
          m_err  = 1;
        end
      end
      if (s_valid) begin
        if (mst[mws] == 2 || (mst[mws] == 0 && !s_sos)) begin
          m_ovf = 1;
        end else begin
          mmem[mws][s_addr] = s_data;
          mbad[mws][s_addr] = m_inj;
          if (s_eos) begin
            mst[mws] = 2;
            mws = !mws;
          end else begin
            mst[mws] = 1;
          end
        end
      end
      if (rel_ok) begin
        mst[mrs] = 0;
        mrs = !mrs;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (reset && cmp_en) begin
      chk("s_ready", 64'(s_ready), 64'(mst[mws] != 2));
      chk("rd_bank_rdy", 64'(rd_bank_rdy), 64'(mst[mrs] == 2));
      chk("ovf", 64'(ovf), 64'(m_ovf));
      chk("rd_valid", 64'(rd_valid), 64'(m_valid));
      chk("rd_err", 64'(rd_err), 64'(m_err));
      chk("rd_data", rd_data, m_data);
`ifdef SM_FV_PARITY_EN
      chk("rd_perr", 64'(rd_perr), 64'(m_perr));
`endif
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle();
    s_valid = 0; s_sos = 0; s_eos = 0; rd_req = 0; rel = 0;
  endtask

  task automatic beat(input bit sos, input bit eos, input int a, input logic [63:0] d);
    s_valid = 1; s_sos = sos; s_eos = eos; s_addr = AW'(a); s_data = d;
    step();
    idle();
  endtask

  task automatic fill(input int n, input int mul, input int off);
    for (int i = 0; i < n; i++) beat(i == 0, i == n - 1, i, 64'(i * mul + off));
  endtask

  task automatic rd(input int a);
    rd_req = 1; rd_addr = AW'(a);
    step();
    idle();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_s_ready"}, 64'(s_ready), 64'd1);
    chk({tag, "_rd_valid"}, 64'(rd_valid), 64'd0);
    chk({tag, "_rd_data"}, rd_data, 64'd0);
    chk({tag, "_rd_err"}, 64'(rd_err), 64'd0);
    chk({tag, "_rd_bank_rdy"}, 64'(rd_bank_rdy), 64'd0);
    chk({tag, "_ovf"}, 64'(ovf), 64'd0);
  endtask

  initial begin
    // Reset state.
    step(); step();
    check_reset_vals("reset");
    #2 reset = 1;
    cmp_en = 1;

    // Read before any buffer completes: one-cycle rd_err.
    rd(0);
    chk("early_rd_err", 64'(rd_err), 64'd1);
    chk("early_rd_valid", 64'(rd_valid), 64'd0);
    step();
    chk("early_rd_err_pulse", 64'(rd_err), 64'd0);

    // Full 64-line stream into B0, data = addr*3.
    fill(64, 3, 0);
    chk("b0_rdy", 64'(rd_bank_rdy), 64'd1);
    rd(10);
    chk("b0_rd_valid", 64'(rd_valid), 64'd1);
    chk("b0_rd_data", rd_data, 64'd30);
    step();
    chk("hold_rd_data", rd_data, 64'd30);

    // Fill B1 without releasing B0: both full, extra beat overflows.
    fill(64, 1, 100);
    chk("both_full_s_ready", 64'(s_ready), 64'd0);
    beat(1, 0, 0, 64'd5);
    chk("ovf_set", 64'(ovf), 64'd1);
    rel = 1;
    step();
    idle();
    chk("after_rel_s_ready", 64'(s_ready), 64'd1);
    rd(7);
    chk("b1_rd_data", rd_data, 64'd107);

    // Read and release in the same cycle: served from the old buffer.
    rd_req = 1; rd_addr = AW'(3); rel = 1;
    step();
    idle();
    chk("rdrel_data", rd_data, 64'd103);
    chk("rdrel_rdy", 64'(rd_bank_rdy), 64'd0);

    // Non-sos beat into an empty buffer is dropped.
    beat(0, 0, 9, 64'd1);
    // One-line stream.
    beat(1, 1, 5, 64'hAA);
    chk("single_rdy", 64'(rd_bank_rdy), 64'd1);
    rd(5);
    chk("single_rd_data", rd_data, 64'hAA);

    // Short stream into B1 with an sos restart; eos coincides with rel of B0.
    beat(1, 0, 0, 64'h10);
    beat(0, 0, 1, 64'h11);
    beat(1, 0, 0, 64'h22);
    rel = 1;
    beat(0, 1, 2, 64'h33);
    chk("eos_rel_s_ready", 64'(s_ready), 64'd1);
    chk("eos_rel_rdy", 64'(rd_bank_rdy), 64'd1);
    rd(0);
    chk("restart_rd_data", rd_data, 64'h22);
    rd(1);
    chk("restart_rd1", rd_data, 64'h11);

`ifdef SM_FV_PARITY_EN
    // Parity: corrupt line 2 of B0 on write.
    for (int i = 0; i < 4; i++) begin
      inj_perr = (i == 2);
      beat(i == 0, i == 3, i, 64'(i * 7 + 1));
    end
    inj_perr = 0;
    rel = 1;
    step();
    idle();
    rd(2);
    chk("perr_valid", 64'(rd_valid), 64'd1);
    chk("perr_set", 64'(rd_perr), 64'd1);
    rd(1);
    chk("perr_clear", 64'(rd_perr), 64'd0);
    rel = 1;
    step();
    idle();
`else
    rel = 1;
    step();
    idle();
`endif

    // Reset mid-fill after 20 beats.
    for (int i = 0; i < 20; i++) beat(i == 0, 1'b0, i, 64'(i));
    cmp_en = 0;
    #3 reset = 0;
    #1 check_reset_vals("async_reset");
    step();
    #2 reset = 1;
    cmp_en = 1;
    rd(20);
    chk("post_reset_rd_err", 64'(rd_err), 64'd1);
    chk("post_reset_rdy", 64'(rd_bank_rdy), 64'd0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sm_fv_pingpong_buf.md
Name: sm_fv_pingpong_buf

Overview:
- Small-FV-side receiver for the iteration feature-value stream emitted by the big FV bank controller (sos/eos/data/line-address stream).
- Captures one replay iteration's lines into one of two local buffers (ping-pong) while the edge-PE side reads the other, previously completed buffer.
- Sits between the big FV bank controller and the edge-PE feature-value read path.

Parameters:
- FV_W, 64, width of one FV line (`FV_bandwidth)
- DEPTH, 64, lines per buffer; power of two
- AW, $clog2(DEPTH), line address width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- s_valid  in  1  stream beat valid
- s_sos  in  1  first beat of an iteration stream
- s_eos  in  1  last beat of an iteration stream
- s_addr  in  AW  line address of beat (stream A field, low AW bits)
- s_data  in  FV_W  line data
- s_ready  out  1  buffer available to accept a new stream
- rd_req  in  1  edge-PE read request
- rd_addr  in  AW  line to read
- rd_valid  out  1  read data valid
- rd_data  out  FV_W  read data
- rd_err  out  1  read attempted with no completed buffer
- rel  in  1  consumer releases current read buffer
- rd_bank_rdy  out  1  a completed buffer is selected for reading
- ovf  out  1  sticky: stream beat dropped

Behaviour:
- Two buffers B0/B1, each DEPTH x FV_W, state per buffer: EMPTY, FILL, DONE.
- Pointers: wr_sel (buffer being filled), rd_sel (buffer being read). Reset: both 0, both buffers EMPTY.
- Reset values: s_ready=1, rd_valid=0, rd_data=0, rd_err=0, rd_bank_rdy=0, ovf=0. Reset is asynchronous; any partial fill is discarded.
- s_ready = 1 when buffer[wr_sel] is EMPTY or FILL.
- Fill:
  - Beat accepted when s_valid & s_ready.
  - s_sos on an accepted beat moves buffer[wr_sel] EMPTY->FILL and writes the line.
  - Accepted beats in FILL write s_data at s_addr.
  - s_eos moves FILL->DONE and toggles wr_sel in that same cycle.
  - A beat carrying both s_sos and s_eos is a one-line stream: EMPTY->DONE directly.
  - A non-sos beat while EMPTY is dropped; ovf is set.
  - s_sos while already in FILL restarts the fill: the line is written and the state stays FILL.
  - s_valid while s_ready=0: beat dropped, ovf set. ovf clears only on reset.
- Read side:
  - rd_bank_rdy = (buffer[rd_sel] == DONE).
  - rd_req with rd_bank_rdy=1: rd_valid=1 and rd_data=buffer[rd_sel][rd_addr] in the next cycle (1-cycle latency, registered). rd_err=0.
  - rd_req with rd_bank_rdy=0: next cycle rd_valid=0, rd_data=0, rd_err=1 (1-cycle pulse).
  - No rd_req: rd_valid=0 and rd_err=0 next cycle; rd_data holds its previous value.
  - rel while rd_bank_rdy=1: buffer[rd_sel] -> EMPTY, rd_sel toggles next cycle. rel with rd_bank_rdy=0 is ignored.
  - rd_req and rel in the same cycle: the read is served from the old buffer, then the release takes effect.
- Simultaneous events:
  - s_eos completing a buffer and rel freeing the other buffer in the same cycle: both state updates apply, and s_ready is 1 in the next cycle.
  - A fill into wr_sel never aliases the rd_sel buffer while that buffer is DONE. This holds because wr_sel only toggles on eos and a DONE buffer is never re-entered before rel.
- Address width: s_addr and rd_addr are truncated to AW bits, with no bounds error.

Optional Feature:
- Macro: SM_FV_PARITY_EN.
- Enabled:
  - Each line stores an extra even-parity bit computed on write.
  - On a read, parity is recomputed on the stored line. A mismatch asserts port rd_perr (1 bit, same cycle as rd_valid).
  - A debug input inj_perr (1 bit) flips the stored parity bit on writes while it is high.
- Disabled: neither port exists and no parity storage is generated.

Test Plan:
- Stream 64 beats (sos at addr 0, eos at addr 63, data=addr*3) into B0 -> rd_bank_rdy=1 next cycle; rd_req addr 10 -> rd_data=30 one cycle later with rd_valid=1.
- Fill B0, then fill B1 without rel -> s_ready=0 after B1 eos; an extra s_valid beat -> ovf=1. rel -> rd_sel=1, and s_ready=1 the following cycle.
- rd_req immediately after reset -> rd_err=1 for exactly one cycle, rd_valid=0.
- Single beat with sos=eos=1 at addr 5, data 0xAA -> buffer DONE; read addr 5 returns 0xAA.
- Assert reset mid-fill after 20 beats -> all outputs at reset values; a read then gives rd_err.
- With SM_FV_PARITY_EN: write a line with inj_perr=1, then read it -> rd_perr=1 alongside rd_valid=1; other lines read with rd_perr=0.
